// File: rtl/regfile_write_scheduler.sv
// Round-robin scheduler sharing the register file's two write ports among NREQ writeback sources.
// Grants are combinational; winning writes are registered and presented on the following cycle.
module regfile_write_scheduler #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_reg,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [AW-1:0]      WriteReg1,
  output logic [DW-1:0]      WriteData1,
  output logic [AW-1:0]      WriteReg2,
  output logic [DW-1:0]      WriteData2,
  output logic [1:0]         RegWrite_signal,
  output logic [15:0]        conflict_count
);
  localparam int PW = $clog2(NREQ);

  logic [AW-1:0] reqRegArr  [NREQ];
  logic [DW-1:0] reqDataArr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : gUnpack
    assign reqRegArr[i]  = req_reg[i*AW +: AW];
    assign reqDataArr[i] = req_data[i*DW +: DW];
  end

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptrNext;
  logic [NREQ-1:0] gntRaw;
  logic            port1Valid;
  logic            port2Valid;
  logic            conflictSeen;
  logic [AW-1:0]   port1Reg;
  logic [AW-1:0]   port2Reg;
  logic [DW-1:0]   port1Data;
  logic [DW-1:0]   port2Data;

  // Scan from ptr; register-0 writes are acknowledged without using a port.
  always_comb begin
    logic [PW-1:0] idx;
    idx          = ptr;
    gntRaw       = '0;
    port1Valid   = 1'b0;
    port2Valid   = 1'b0;
    conflictSeen = 1'b0;
    port1Reg     = '0;
    port2Reg     = '0;
    port1Data    = '0;
    port2Data    = '0;
    ptrNext      = ptr;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        if (reqRegArr[idx] == '0) begin
          gntRaw[idx] = 1'b1;
        end else if (!port1Valid) begin
          port1Valid  = 1'b1;
          port1Reg    = reqRegArr[idx];
          port1Data   = reqDataArr[idx];
          gntRaw[idx] = 1'b1;
          ptrNext     = PW'((int'(idx) + 1) % NREQ);
        end else if (reqRegArr[idx] == port1Reg) begin
          conflictSeen = 1'b1;
        end else if (!port2Valid) begin
          port2Valid  = 1'b1;
          port2Reg    = reqRegArr[idx];
          port2Data   = reqDataArr[idx];
          gntRaw[idx] = 1'b1;
          ptrNext     = PW'((int'(idx) + 1) % NREQ);
        end
      end
    end
  end

  assign gnt = reset ? '0 : gntRaw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr             <= '0;
      RegWrite_signal <= 2'b00;
      WriteReg1       <= '0;
      WriteData1      <= '0;
      WriteReg2       <= '0;
      WriteData2      <= '0;
      conflict_count  <= '0;
    end else begin
      RegWrite_signal <= {port1Valid, port2Valid};
      if (port1Valid) begin
        WriteReg1  <= port1Reg;
        WriteData1 <= port1Data;
        ptr        <= ptrNext;
      end
      if (port2Valid) begin
        WriteReg2  <= port2Reg;
        WriteData2 <= port2Data;
      end
      if (conflictSeen && conflict_count != 16'hFFFF)
        conflict_count <= conflict_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Scoreboard bench for regfile_write_scheduler: a queue-based arbitration model predicts grants
// and registered writes; a separate monitor pops predictions whenever the DUT presents a write.
module tb_regfile_write_scheduler;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_reg;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      WriteReg1, WriteReg2;
  logic [DW-1:0]      WriteData1, WriteData2;
  logic [1:0]         RegWrite_signal;
  logic [15:0]        conflict_count;

  regfile_write_scheduler #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_reg(req_reg), .req_data(req_data),
    .gnt(gnt), .WriteReg1(WriteReg1), .WriteData1(WriteData1), .WriteReg2(WriteReg2),
    .WriteData2(WriteData2), .RegWrite_signal(RegWrite_signal), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    en;
    logic [AW-1:0] r1;
    logic [DW-1:0] d1;
    logic [AW-1:0] r2;
    logic [DW-1:0] d2;
  } wr_t;

  wr_t expQ[$];
  int  nChecks = 0;
  int  nPass   = 0;

  bit            reqV   [NREQ];
  logic [AW-1:0] reqDst [NREQ];
  logic [DW-1:0] reqDat [NREQ];
  int            refillMode;   // 0: drop when granted, 1: random, 2: re-request same destination
  int            mPtr, mCount;
  logic [AW-1:0] mR1, mR2;
  logic [DW-1:0] mD1, mD2;
  logic [NREQ-1:0] lastGnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic modelReset();
    mPtr = 0; mCount = 0; mR1 = '0; mR2 = '0; mD1 = '0; mD2 = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i]               = reqV[i];
      req_reg[i*AW +: AW]  = reqDst[i];
      req_data[i*DW +: DW] = reqDat[i];
    end
  endtask

  // Walk requesters in rotation order, collecting up to two port winners.
  task automatic modelArb(output logic [NREQ-1:0] g, output wr_t w, output bit conf, output int nPtr);
    int order[$];
    int ports[$];
    g = '0; conf = 0; w = '0;
    for (int k = 0; k < NREQ; k++) order.push_back((mPtr + k) % NREQ);
    foreach (order[j]) begin
      int i;
      i = order[j];
      if (reqV[i]) begin
        if (reqDst[i] == 0) g[i] = 1'b1;
        else if (ports.size() == 0) ports.push_back(i);
        else if (reqDst[i] == reqDst[ports[0]]) conf = 1;
        else if (ports.size() < 2) ports.push_back(i);
      end
    end
    foreach (ports[j]) g[ports[j]] = 1'b1;
    nPtr = (ports.size() > 0) ? (ports[ports.size()-1] + 1) % NREQ : mPtr;
    if (ports.size() > 0) begin mR1 = reqDst[ports[0]]; mD1 = reqDat[ports[0]]; end
    if (ports.size() > 1) begin mR2 = reqDst[ports[1]]; mD2 = reqDat[ports[1]]; end
    w.en = {ports.size() > 0, ports.size() > 1};
    w.r1 = mR1; w.d1 = mD1; w.r2 = mR2; w.d2 = mD2;
  endtask

  task automatic newReq(input int i);
    reqV[i]   = 1;
    reqDst[i] = AW'($urandom_range(7));
    reqDat[i] = $urandom;
  endtask

  task automatic refill(input logic [NREQ-1:0] g);
    for (int i = 0; i < NREQ; i++) begin
      if (g[i]) begin
        reqV[i] = 0;
        if (refillMode == 1 && $urandom_range(3) != 0) newReq(i);
        else if (refillMode == 2) begin reqV[i] = 1; reqDat[i] = $urandom; end
      end else if (refillMode == 1 && !reqV[i] && $urandom_range(1) == 1) begin
        newReq(i);
      end
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic stepCycle();
    logic [NREQ-1:0] g;
    wr_t w;
    bit  conf;
    int  nPtr;
    drive();
    @(negedge clk);
    modelArb(g, w, conf, nPtr);
    chk("gnt", gnt, g);
    chk("conflict_count", conflict_count, mCount);
    if (w.en != 2'b00) expQ.push_back(w);
    mPtr = nPtr;
    if (conf && mCount < 65535) mCount++;
    lastGnt = gnt;
    @(posedge clk); #1;
    refill(g);
  endtask

  task automatic setReq(input int i, input bit v, input int dst, input int dat);
    reqV[i] = v; reqDst[i] = AW'(dst); reqDat[i] = DW'(dat);
  endtask

  initial begin
    wr_t e;
    forever begin
      @(posedge clk); #2;
      if (!reset && RegWrite_signal != 2'b00) begin
        if (expQ.size() == 0) chk("unexpected_write", RegWrite_signal, 2'b00);
        else begin
          e = expQ.pop_front();
          chk("RegWrite_signal", RegWrite_signal, e.en);
          chk("WriteReg1", WriteReg1, e.r1);
          chk("WriteData1", WriteData1, e.d1);
          chk("WriteReg2", WriteReg2, e.r2);
          chk("WriteData2", WriteData2, e.d2);
        end
      end
    end
  end

  initial begin
    int cnt[NREQ];
    int miss[NREQ];
    int maxMiss[NREQ];
    reset = 1'b1;
    refillMode = 0;
    modelReset();
    setReq(0, 1, 5, 14); setReq(1, 1, 6, 15); setReq(2, 1, 7, 16);
    drive();
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_RegWrite", RegWrite_signal, 2'b00);
    chk("rst_WriteReg1", WriteReg1, 0);
    chk("rst_WriteData1", WriteData1, 0);
    chk("rst_WriteReg2", WriteReg2, 0);
    chk("rst_WriteData2", WriteData2, 0);
    chk("rst_conflict", conflict_count, 0);
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) reqV[i] = 0;
    drive();
    @(posedge clk); #1;

    // Three distinct destinations: two ports this cycle, the third next cycle.
    setReq(0, 1, 5, 14); setReq(1, 1, 6, 15); setReq(2, 1, 7, 16);
    stepCycle();
    chk("t1_gnt_a", lastGnt, 3'b011);
    chk("t1_RegWrite_a", RegWrite_signal, 2'b11);
    chk("t1_WriteReg1", WriteReg1, 5);
    chk("t1_WriteData1", WriteData1, 14);
    chk("t1_WriteReg2", WriteReg2, 6);
    chk("t1_WriteData2", WriteData2, 15);
    stepCycle();
    chk("t1_gnt_b", lastGnt, 3'b100);
    chk("t1_RegWrite_b", RegWrite_signal, 2'b10);
    chk("t1_WriteReg1_b", WriteReg1, 7);
    chk("t1_WriteData1_b", WriteData1, 16);

    // Same-destination conflict.
    setReq(0, 1, 10, 14); setReq(1, 1, 10, 20);
    stepCycle();
    chk("t2_gnt_a", lastGnt, 3'b001);
    chk("t2_RegWrite_a", RegWrite_signal, 2'b10);
    chk("t2_conflict", conflict_count, 1);
    stepCycle();
    chk("t2_gnt_b", lastGnt, 3'b010);
    chk("t2_WriteReg1", WriteReg1, 10);
    chk("t2_WriteData1", WriteData1, 20);

    // Register-0 request rides along without a port.
    setReq(0, 1, 0, 33); setReq(2, 1, 11, 44);
    stepCycle();
    chk("t3_gnt", lastGnt, 3'b101);
    chk("t3_RegWrite", RegWrite_signal, 2'b10);
    chk("t3_WriteReg1", WriteReg1, 11);

    // Continuous distinct requests: pointer must be back at 0 after t3.
    setReq(0, 1, 1, 100); setReq(1, 1, 2, 200); setReq(2, 1, 3, 300);
    refillMode = 2;
    for (int i = 0; i < NREQ; i++) begin cnt[i] = 0; miss[i] = 0; maxMiss[i] = 0; end
    for (int c = 0; c < 6; c++) begin
      stepCycle();
      if (c == 0) chk("t3_ptr_gnt", lastGnt, 3'b011);
      for (int i = 0; i < NREQ; i++) begin
        if (lastGnt[i]) begin cnt[i]++; miss[i] = 0; end
        else begin miss[i]++; if (miss[i] > maxMiss[i]) maxMiss[i] = miss[i]; end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      chk($sformatf("fair_count%0d", i), cnt[i], 4);
      chk($sformatf("fair_maxmiss%0d", i), maxMiss[i], 1);
    end

    refillMode = 1;
    repeat (1500) stepCycle();

    // Asynchronous reset between edges.
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_RegWrite", RegWrite_signal, 2'b00);
    chk("midrst_conflict", conflict_count, 0);
    chk("midrst_gnt", gnt, 3'b000);
    chk("midrst_queue_drained", expQ.size(), 0);
    expQ.delete();
    modelReset();
    @(posedge clk); #1;
    reset = 1'b0;
    refillMode = 0;
    setReq(0, 1, 1, 7); setReq(1, 1, 2, 8); setReq(2, 1, 3, 9);
    stepCycle();
    chk("postrst_gnt", lastGnt, 3'b011);
    stepCycle();

    // Saturate the conflict counter.
    setReq(0, 1, 9, 1); setReq(1, 1, 9, 2); setReq(2, 0, 4, 3);
    refillMode = 2;
    repeat (65540) stepCycle();
    chk("sat_conflict", conflict_count, 16'hFFFF);

    refillMode = 0;
    for (int i = 0; i < NREQ; i++) reqV[i] = 0;
    repeat (3) stepCycle();
    chk("final_queue_empty", expQ.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
